macro_updown_cnt: RTL and testbench
===================================

// Module: macro_updown_cnt
//
// PURPOSE
//  Parametrised registered up/down counter with wrap-around at MAX_VAL, carry/borrow strobes,
//  synchronous clear and load. Provides ring indices, credit counters and occupancy counts to
//  queue/FIFO control logic. Next-state arithmetic sits in a combinational inc/dec core.
//
// PARAMETERS
//  WIDTH      4             counter width in bits, >= 1
//  MAX_VAL    2**WIDTH-1    terminal count, <= 2**WIDTH-1; counting is modulo MAX_VAL+1
//  RESET_VAL  0             value of q after reset, <= MAX_VAL
//
// PORTS
//  clk       in   1      clock, rising edge
//  resetn    in   1      asynchronous active-low reset
//  clear     in   1      synchronous clear to RESET_VAL
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  load value
//  inc       in   1      count up by 1
//  dec       in   1      count down by 1
//  q         out  WIDTH  registered count
//  carry     out  1      registered strobe: the last update wrapped (or saturated) upward
//  borrow    out  1      registered strobe: the last update wrapped (or saturated) downward
//  is_zero   out  1      q == 0, combinational from q
//  is_max    out  1      q == MAX_VAL, combinational from q
//
// BEHAVIOUR
//  - Reset (resetn low, asynchronous): q=RESET_VAL, carry=0, borrow=0. Release takes effect on the next edge.
//  - Each clock edge applies one of the following, in priority order:
//    1) clear: q<=RESET_VAL; carry/borrow<=0.
//    2) load: q<=min(load_val, MAX_VAL); out-of-range values clamp silently; carry/borrow<=0.
//    3) inc && !dec: q<=(q==MAX_VAL) ? 0 : q+1; carry<=(q==MAX_VAL); borrow<=0.
//    4) dec && !inc: q<=(q==0) ? MAX_VAL : q-1; borrow<=(q==0); carry<=0.
//    5) inc && dec, or neither: q holds; carry/borrow<=0.
//  - Latency: q, carry and borrow are valid one cycle after the request. Strobes are 1 cycle wide and
//    cycle-aligned with the new q. There is no handshake; a request is accepted every cycle.
//  - Arithmetic is unsigned with a WIDTH+1-bit intermediate. The wrap compare uses MAX_VAL, not 2**WIDTH,
//    so non-power-of-two moduli are exact.
//  - A mid-operation reset overrides any request in the same cycle.
//  - clear/load asserted together with inc/dec: inc/dec is dropped, with no strobe.
//
// CONFIGURATION
//  MACRO_UPDOWN_CNT_SAT_EN
//  - Defined: saturating mode.
//    - inc at MAX_VAL holds q at MAX_VAL and pulses carry.
//    - dec at 0 holds q at 0 and pulses borrow.
//    - Strobes then mean a rejected request.
//  - Undefined: wrapping mode, as listed in BEHAVIOUR.
//  - All other behaviour is identical in both modes.
//
// STRUCTURE
//  - Shared header macro_updown_cnt_defs.vh holds:
//    - mode-select define defaults;
//    - localparam helpers: MAX_VAL range check, WIDTH+1 intermediate width;
//    - encoding of the op select {clear, load, inc, dec}.
//  - One sub-module, macro_incdec_n (combinational): inputs d[WIDTH-1:0], dec, max[WIDTH-1:0];
//    outputs q[WIDTH-1:0] and c (wrap flag). It generalises the 2-bit dec/inc table to arbitrary width and modulus.
//  - The top level holds the registers, the priority mux and the saturation gating.
//
// TESTING
//  1. Reset: WIDTH=4, RESET_VAL=5, resetn low mid-count -> q=5, carry=borrow=0 immediately,
//     without waiting for a clock edge.
//  2. Wrap up: MAX_VAL=9, q=9, inc=1 -> next cycle q=0, carry=1, then carry=0 the cycle after.
//  3. Wrap down: MAX_VAL=9, q=0, dec=1 -> q=9, borrow=1. Under SAT_EN: q stays 0, borrow=1.
//  4. Simultaneous inputs:
//     - inc=dec=1 at q=3 -> q stays 3, no strobes;
//     - load=1, load_val=12, MAX_VAL=9, inc=1 -> q=9, no carry.
//  5. Priority: clear=load=inc=1 at q=7 -> q=RESET_VAL. is_zero/is_max track q combinationally
//     across a full 0..MAX_VAL..0 sweep.
//  6. Randomised run against a reference model: 10k cycles, random clear/load/inc/dec,
//     WIDTH in {1,2,5}, both modes -> exact q/strobe match every cycle.

Source files
------------

// File: rtl/macro_updown_cnt_pkg.sv
// Shared types and elaboration helpers for the up/down counter: op-select
// encoding, strobe bundle, parameter range checks and intermediate widths.
package macro_updown_cnt_pkg;

  // One op per edge, already resolved by priority.
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_INC   = 3'd1,
    OP_DEC   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_CLEAR = 3'd4
  } op_e;

  typedef struct packed {
    logic carry;
    logic borrow;
  } strobe_t;

  function automatic op_e decode_op(input logic clear, input logic load,
                                    input logic inc, input logic dec);
    if (clear)
      return OP_CLEAR;
    if (load)
      return OP_LOAD;
    if (inc && !dec)
      return OP_INC;
    if (dec && !inc)
      return OP_DEC;
    return OP_HOLD;
  endfunction

  function automatic longint full_scale(input int width);
    return (longint'(1) << width) - 64'sd1;
  endfunction

  function automatic bit max_val_ok(input int width, input longint max_val,
                                    input longint reset_val);
    return (width >= 1) && (max_val >= 0) && (max_val <= full_scale(width)) &&
           (reset_val >= 0) && (reset_val <= max_val);
  endfunction

  // Arithmetic is carried one bit wider so the top bit exposes the wrap.
  function automatic int ext_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/macro_updown_cnt_if.sv
// Request/status bundle of the up/down counter; the counter is the slave,
// the controlling logic is the master.
interface macro_updown_cnt_if #(
  parameter int WIDTH = 4
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] q;
  logic             carry;
  logic             borrow;
  logic             is_zero;
  logic             is_max;

  modport master (
    output clear, load, load_val, inc, dec,
    input  q, carry, borrow, is_zero, is_max
  );

  modport slave (
    input  clear, load, load_val, inc, dec,
    output q, carry, borrow, is_zero, is_max
  );
endinterface

// File: rtl/macro_updown_cnt_incdec_n.sv
// Combinational modulo-(max+1) increment/decrement core with a wrap flag;
// assumes d <= max, which the owning register guarantees.
module macro_incdec_n
  import macro_updown_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  input  logic             dec,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] q,
  output logic             c
);
  localparam int EW = ext_width(WIDTH);

  logic [EW-1:0] d_ext;
  logic [EW-1:0] max_ext;
  logic [EW-1:0] inc_sum;
  logic [EW-1:0] dec_diff;
  logic          inc_wrap;
  logic          dec_wrap;

  assign d_ext    = {1'b0, d};
  assign max_ext  = {1'b0, max};
  assign inc_sum  = d_ext + EW'(1);
  assign dec_diff = d_ext - EW'(1);

  // Comparing against max (not 2**WIDTH) keeps non-power-of-two moduli exact;
  // the decrement underflow shows up as the extra top bit.
  assign inc_wrap = (inc_sum > max_ext);
  assign dec_wrap = dec_diff[EW-1];

  always_comb begin
    c = 1'b0;
    q = '0;
    if (dec) begin
      c = dec_wrap;
      q = dec_wrap ? max : dec_diff[WIDTH-1:0];
    end else begin
      c = inc_wrap;
      q = inc_wrap ? '0 : inc_sum[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/macro_updown_cnt.sv
// Registered up/down counter with wrap at MAX_VAL, carry/borrow strobes, clear and load.
// Define MACRO_UPDOWN_CNT_SAT_EN to saturate at the ends instead of wrapping.
module macro_updown_cnt
  import macro_updown_cnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter int RESET_VAL = 0
) (
  input logic          clk,
  input logic          resetn,
  macro_updown_cnt_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

`ifdef MACRO_UPDOWN_CNT_SAT_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  if (!max_val_ok(WIDTH, longint'(MAX_VAL), longint'(RESET_VAL))) begin : g_bad_cfg
    $error("macro_updown_cnt: need WIDTH>=1, MAX_VAL<=2**WIDTH-1, RESET_VAL<=MAX_VAL");
  end

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  strobe_t          strobe_reg;
  strobe_t          strobe_next;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_q;
  logic             step_wrap;
  op_e              op;

  assign op = decode_op(bus.clear, bus.load, bus.inc, bus.dec);

  // With a full-scale modulus every load value is legal, so no clamp is built.
  if (longint'(MAX_VAL) == full_scale(WIDTH)) begin : g_no_clamp
    assign load_clamped = bus.load_val;
  end else begin : g_clamp
    assign load_clamped = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
  end

  macro_incdec_n #(
    .WIDTH (WIDTH)
  ) u_core (
    .d   (q_reg),
    .dec (op == OP_DEC),
    .max (MAX_Q),
    .q   (step_q),
    .c   (step_wrap)
  );

  always_comb begin
    q_next      = q_reg;
    strobe_next = '0;
    case (op)
      OP_CLEAR: q_next = RST_Q;
      OP_LOAD:  q_next = load_clamped;
      OP_INC: begin
        // In saturating mode the strobe flags a rejected step and q stays put.
        q_next            = (SAT_MODE && step_wrap) ? q_reg : step_q;
        strobe_next.carry = step_wrap;
      end
      OP_DEC: begin
        q_next             = (SAT_MODE && step_wrap) ? q_reg : step_q;
        strobe_next.borrow = step_wrap;
      end
      default: q_next = q_reg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_reg      <= RST_Q;
      strobe_reg <= '0;
    end else begin
      q_reg      <= q_next;
      strobe_reg <= strobe_next;
    end
  end

  assign bus.q       = q_reg;
  assign bus.carry   = strobe_reg.carry;
  assign bus.borrow  = strobe_reg.borrow;
  assign bus.is_zero = (q_reg == '0);
  assign bus.is_max  = (q_reg == MAX_Q);
endmodule

// File: tb/tb_macro_updown_cnt.sv
// Self-checking bench: directed corner cases on a mod-10 counter, then a random
// run of four differently sized counters against an arithmetic reference model.
module tb_macro_updown_cnt;
`ifdef MACRO_UPDOWN_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int NI = 4;
  localparam int WID  [NI] = '{4, 1, 2, 5};
  localparam int MAXV [NI] = '{9, 1, 2, 23};
  localparam int RSTV [NI] = '{5, 0, 1, 3};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  macro_updown_cnt_if #(.WIDTH(4)) if0 ();
  macro_updown_cnt_if #(.WIDTH(1)) if1 ();
  macro_updown_cnt_if #(.WIDTH(2)) if2 ();
  macro_updown_cnt_if #(.WIDTH(5)) if3 ();

  macro_updown_cnt #(.WIDTH(4), .MAX_VAL(9),  .RESET_VAL(5)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  macro_updown_cnt #(.WIDTH(1), .MAX_VAL(1),  .RESET_VAL(0)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));
  macro_updown_cnt #(.WIDTH(2), .MAX_VAL(2),  .RESET_VAL(1)) dut2 (.clk(clk), .resetn(resetn), .bus(if2));
  macro_updown_cnt #(.WIDTH(5), .MAX_VAL(23), .RESET_VAL(3)) dut3 (.clk(clk), .resetn(resetn), .bus(if3));

  int n_tests = 0;
  int n_fail  = 0;

  bit r_clear [NI];
  bit r_load  [NI];
  int r_lv    [NI];
  bit r_inc   [NI];
  bit r_dec   [NI];
  int mq [NI];
  int mc [NI];
  int mb [NI];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k] = RSTV[k];
      mc[k] = 0;
      mb[k] = 0;
    end
  endtask

  // Counting is arithmetic modulo MAX+1 (or clipped to [0,MAX] when saturating).
  task automatic model_step(input int k);
    int m = MAXV[k];
    int up = mq[k] + 1;
    int dn = mq[k] - 1;
    mc[k] = 0;
    mb[k] = 0;
    if (r_clear[k])
      mq[k] = RSTV[k];
    else if (r_load[k])
      mq[k] = (r_lv[k] > m) ? m : r_lv[k];
    else if (r_inc[k] && !r_dec[k]) begin
      mc[k] = (up > m) ? 1 : 0;
      mq[k] = SAT ? ((up > m) ? m : up) : up % (m + 1);
    end else if (r_dec[k] && !r_inc[k]) begin
      mb[k] = (dn < 0) ? 1 : 0;
      mq[k] = SAT ? ((dn < 0) ? 0 : dn) : (dn + m + 1) % (m + 1);
    end
  endtask

  task automatic drive_all();
    if0.clear = r_clear[0]; if0.load = r_load[0]; if0.load_val = 4'(r_lv[0]); if0.inc = r_inc[0]; if0.dec = r_dec[0];
    if1.clear = r_clear[1]; if1.load = r_load[1]; if1.load_val = 1'(r_lv[1]); if1.inc = r_inc[1]; if1.dec = r_dec[1];
    if2.clear = r_clear[2]; if2.load = r_load[2]; if2.load_val = 2'(r_lv[2]); if2.inc = r_inc[2]; if2.dec = r_dec[2];
    if3.clear = r_clear[3]; if3.load = r_load[3]; if3.load_val = 5'(r_lv[3]); if3.inc = r_inc[3]; if3.dec = r_dec[3];
  endtask

  task automatic check_all();
    chk("q0", 32'(if0.q), 32'(mq[0]));  chk("carry0", 32'(if0.carry), 32'(mc[0]));  chk("borrow0", 32'(if0.borrow), 32'(mb[0]));
    chk("is_zero0", 32'(if0.is_zero), 32'(mq[0] == 0));  chk("is_max0", 32'(if0.is_max), 32'(mq[0] == MAXV[0]));
    chk("q1", 32'(if1.q), 32'(mq[1]));  chk("carry1", 32'(if1.carry), 32'(mc[1]));  chk("borrow1", 32'(if1.borrow), 32'(mb[1]));
    chk("is_zero1", 32'(if1.is_zero), 32'(mq[1] == 0));  chk("is_max1", 32'(if1.is_max), 32'(mq[1] == MAXV[1]));
    chk("q2", 32'(if2.q), 32'(mq[2]));  chk("carry2", 32'(if2.carry), 32'(mc[2]));  chk("borrow2", 32'(if2.borrow), 32'(mb[2]));
    chk("is_zero2", 32'(if2.is_zero), 32'(mq[2] == 0));  chk("is_max2", 32'(if2.is_max), 32'(mq[2] == MAXV[2]));
    chk("q3", 32'(if3.q), 32'(mq[3]));  chk("carry3", 32'(if3.carry), 32'(mc[3]));  chk("borrow3", 32'(if3.borrow), 32'(mb[3]));
    chk("is_zero3", 32'(if3.is_zero), 32'(mq[3] == 0));  chk("is_max3", 32'(if3.is_max), 32'(mq[3] == MAXV[3]));
  endtask

  task automatic apply();
    drive_all();
    for (int k = 0; k < NI; k++)
      model_step(k);
    tick();
    check_all();
  endtask

  // Directed step on instance 0; the other counters idle.
  task automatic step0(input bit c, input bit l, input int lv, input bit i, input bit d);
    for (int k = 0; k < NI; k++) begin
      r_clear[k] = 1'b0; r_load[k] = 1'b0; r_lv[k] = 0; r_inc[k] = 1'b0; r_dec[k] = 1'b0;
    end
    r_clear[0] = c; r_load[0] = l; r_lv[0] = lv; r_inc[0] = i; r_dec[0] = d;
    apply();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      r_clear[k] = 1'b0; r_load[k] = 1'b0; r_lv[k] = 0; r_inc[k] = 1'b0; r_dec[k] = 1'b0;
    end
    drive_all();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_q", 32'(if0.q), 32'd5);
    resetn = 1'b1;
    check_all();
    step0(0, 0, 0, 0, 0);

    // Wrap / saturate upward, then an asynchronous reset while carry is high.
    step0(0, 1, 8, 0, 0);
    step0(0, 0, 0, 1, 0);
    chk("pre_wrap_q", 32'(if0.q), 32'd9);
    step0(0, 0, 0, 1, 0);
    chk("wrap_up_q", 32'(if0.q), SAT ? 32'd9 : 32'd0);
    chk("wrap_up_carry", 32'(if0.carry), 32'd1);
    #1 resetn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_q", 32'(if0.q), 32'd5);
    chk("async_rst_carry", 32'(if0.carry), 32'd0);
    chk("async_rst_borrow", 32'(if0.borrow), 32'd0);
    check_all();
    #1 resetn = 1'b1;

    // Carry lasts exactly one cycle.
    step0(0, 1, 9, 0, 0);
    step0(0, 0, 0, 1, 0);
    chk("carry_pulse", 32'(if0.carry), 32'd1);
    step0(0, 0, 0, 0, 0);
    chk("carry_drop", 32'(if0.carry), 32'd0);

    // Wrap / saturate downward.
    step0(0, 1, 0, 0, 0);
    step0(0, 0, 0, 0, 1);
    chk("wrap_dn_q", 32'(if0.q), SAT ? 32'd0 : 32'd9);
    chk("wrap_dn_borrow", 32'(if0.borrow), 32'd1);

    // Simultaneous inputs and priority.
    step0(0, 1, 3, 0, 0);
    step0(0, 0, 0, 1, 1);
    chk("incdec_hold_q", 32'(if0.q), 32'd3);
    chk("incdec_no_strobe", 32'(if0.carry | if0.borrow), 32'd0);
    step0(0, 1, 12, 1, 0);
    chk("load_clamp_q", 32'(if0.q), 32'd9);
    chk("load_no_carry", 32'(if0.carry), 32'd0);
    step0(0, 1, 7, 0, 0);
    step0(1, 1, 2, 1, 0);
    chk("prio_clear_q", 32'(if0.q), 32'd5);

    // Full 0..MAX..0 sweep; flags are checked each cycle by check_all.
    step0(0, 1, 0, 0, 0);
    chk("sweep_start_zero", 32'(if0.is_zero), 32'd1);
    for (int i = 0; i < 9; i++)
      step0(0, 0, 0, 1, 0);
    chk("sweep_top_max", 32'(if0.is_max), 32'd1);
    for (int i = 0; i < 9; i++)
      step0(0, 0, 0, 0, 1);
    chk("sweep_end_zero", 32'(if0.is_zero), 32'd1);

    // Random run across all four configurations.
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < NI; k++) begin
        r_clear[k] = ($urandom_range(0, 15) == 0);
        r_load[k]  = ($urandom_range(0, 7) == 0);
        r_lv[k]    = int'($urandom_range(0, (1 << WID[k]) - 1));
        r_inc[k]   = 1'($urandom_range(0, 1));
        r_dec[k]   = 1'($urandom_range(0, 1));
      end
      apply();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
